// File: rtl/tx_tse_tsq.sv
// tx_tse_tsq -- transmit-side PTPv2 (L2) event timestamp engine with record queue.
//
// Sits on the 64-bit XGMII tx path between MAC and PCS. Each tx_clk_en_i cycle
// registers txd_i/txc_i onto txd_o/txc_o. In parallel it parses event frames.
// A frame that passes the header checks pushes one record into a DEPTH-entry
// first-word-fall-through queue. The record is the SFD timestamp plus the
// sourcePortIdentity, sequenceId and messageType.
//
// Optional feature: define TX_TSE_TSQ_VLAN_EN to accept one 802.1Q tag
// (ethertype 16'h8100) ahead of the PTP ethertype. All PTP offsets then move
// by 4 bytes. Without the macro, 16'h8100 counts as a non-PTP ethertype.
//
// Ports:
//   tx_clk, tx_rst         clock, synchronous active-high reset
//   tx_clk_en_i            qualifies input words and all parser state updates
//   txd_i/txc_i            XGMII in (lane 0 = bits [7:0])
//   txd_o/txc_o            XGMII out, one enabled cycle later
//   sfd_timestamp_i        {48b s, 32b ns}, sampled on the start word
//   sfd_ts_frac_ns_i       fractional ns, sampled on the start word
//   tsu_cfg_i              [0] enable new frames, [1] hold overflow count at 0
//   ts_valid_o/ts_pop_i    queue head valid / consume head (not clock-enable gated)
//   ts_time_o..ts_msgtype_o  head record fields (0 while empty)
//   ts_count_o             occupancy 0..DEPTH
//   ts_ovf_cnt_o           dropped records, saturating at 255
//   int_tx_ptp_o           one-cycle pulse per committed record (incl. dropped)
module tx_tse_tsq #(
  parameter int          DEPTH    = 8,
  parameter int          AW       = 3,
  parameter logic [15:0] MSG_MASK = 16'h000F
) (
  input  logic          tx_clk,
  input  logic          tx_rst,
  input  logic          tx_clk_en_i,
  input  logic [63:0]   txd_i,
  input  logic [7:0]    txc_i,
  output logic [63:0]   txd_o,
  output logic [7:0]    txc_o,
  input  logic [79:0]   sfd_timestamp_i,
  input  logic [15:0]   sfd_ts_frac_ns_i,
  input  logic [31:0]   tsu_cfg_i,
  output logic          ts_valid_o,
  input  logic          ts_pop_i,
  output logic [95:0]   ts_time_o,
  output logic [79:0]   ts_spid_o,
  output logic [15:0]   ts_seqid_o,
  output logic [3:0]    ts_msgtype_o,
  output logic [AW:0]   ts_count_o,
  output logic [7:0]    ts_ovf_cnt_o,
  output logic          int_tx_ptp_o
);

`ifdef TX_TSE_TSQ_VLAN_EN
  localparam bit VLAN_EN = 1'b1;
`else
  localparam bit VLAN_EN = 1'b0;
`endif

  localparam logic [63:0] IDLE_D = {8{8'h07}};

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_WAIT_EOF} state_t;

  typedef struct packed {
    logic [95:0] tstamp;
    logic [79:0] spid;
    logic [15:0] seqid;
    logic [3:0]  msgtype;
  } rec_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // index of the word currently on txd_i
  logic        vlan_q, vlan_d;
  logic [95:0] ts_q, ts_d;
  logic [79:0] spid_q, spid_d;
  logic [15:0] seqid_q, seqid_d;
  logic [3:0]  msgtype_q, msgtype_d;
  logic        commit_q, commit_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    ovf_q, ovf_d;
  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];

  logic [63:0] swp;                 // word byte-swapped: lane 0 lands in [63:56]
  logic        is_start, start_ok, is_term, has_ctrl;
  logic        pop, full, wr_en, drop;
  rec_t        head;
  logic        unused_cfg;

  assign unused_cfg = ^tsu_cfg_i[31:2];

  // Decode of the incoming word
  always_comb begin
    swp     = '0;
    is_term = 1'b0;
    for (int i = 0; i < 8; i++) begin
      swp[63-8*i -: 8] = txd_i[8*i +: 8];
      if (txc_i[i] && txd_i[8*i +: 8] == 8'hFD) is_term = 1'b1;
    end
  end

  assign is_start = txc_i[0] && (txd_i[7:0] == 8'hFB);
  assign start_ok = is_start && tsu_cfg_i[0];
  assign has_ctrl = |txc_i;

  // Parser FSM and header capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vlan_d    = vlan_q;
    ts_d      = ts_q;
    spid_d    = spid_q;
    seqid_d   = seqid_q;
    msgtype_d = msgtype_q;
    commit_d  = 1'b0;
    txd_d     = txd_q;
    txc_d     = txc_q;
    if (tx_clk_en_i) begin
      txd_d = txd_i;
      txc_d = txc_i;
      // A start word always (re)opens a frame, dropping any partial record
      if (start_ok) begin
        state_d = ST_HDR;
        cnt_d   = 4'd1;
        vlan_d  = 1'b0;
        ts_d    = {sfd_timestamp_i, sfd_ts_frac_ns_i};
      end else if (is_start) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_HDR: begin
            if (has_ctrl) begin
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 4'd1;
              case (cnt_q)
                4'd2: begin
                  if (VLAN_EN && swp[31:16] == 16'h8100) begin
                    vlan_d = 1'b1;
                  end else if (swp[31:16] != 16'h88F7 || swp[3:0] != 4'd2 ||
                               !MSG_MASK[swp[11:8]]) begin
                    state_d = ST_WAIT_EOF;
                  end else begin
                    msgtype_d = swp[11:8];
                  end
                end
                4'd3: begin
                  if (vlan_q) begin
                    if (swp[63:48] != 16'h88F7 || swp[35:32] != 4'd2 ||
                        !MSG_MASK[swp[43:40]]) begin
                      state_d = ST_WAIT_EOF;
                    end else begin
                      msgtype_d = swp[43:40];
                    end
                  end
                end
                4'd5: begin
                  if (vlan_q) spid_d[79:64] = swp[15:0];
                  else        spid_d[79:32] = swp[47:0];
                end
                4'd6: begin
                  if (vlan_q) begin
                    spid_d[63:0] = swp;
                  end else begin
                    spid_d[31:0] = swp[63:32];
                    seqid_d      = swp[31:16];
                    commit_d     = 1'b1;
                    state_d      = ST_WAIT_EOF;
                  end
                end
                4'd7: begin
                  seqid_d  = swp[63:48];
                  commit_d = 1'b1;
                  state_d  = ST_WAIT_EOF;
                end
                default: ;
              endcase
            end
          end
          ST_WAIT_EOF: if (is_term) state_d = ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Record queue. The read side runs every clock, independent of tx_clk_en_i.
  assign pop   = ts_pop_i && (count_q != '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign wr_en = commit_q && (!full || pop);
  assign drop  = commit_q && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    ovf_d    = ovf_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = '{tstamp: ts_q, spid: spid_q, seqid: seqid_q, msgtype: msgtype_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    // Clear is a level and wins over a same-cycle drop
    if (tsu_cfg_i[1])                   ovf_d = 8'd0;
    else if (drop && ovf_q != 8'hFF)    ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      vlan_q    <= 1'b0;
      ts_q      <= '0;
      spid_q    <= '0;
      seqid_q   <= '0;
      msgtype_q <= '0;
      commit_q  <= 1'b0;
      txd_q     <= IDLE_D;
      txc_q     <= 8'hFF;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vlan_q    <= vlan_d;
      ts_q      <= ts_d;
      spid_q    <= spid_d;
      seqid_q   <= seqid_d;
      msgtype_q <= msgtype_d;
      commit_q  <= commit_d;
      txd_q     <= txd_d;
      txc_q     <= txc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: the head outputs are gated by the occupancy
  always_ff @(posedge tx_clk) begin
    mem_q <= mem_d;
  end

  assign head         = mem_q[rd_ptr_q];
  assign ts_valid_o   = (count_q != '0);
  assign ts_time_o    = ts_valid_o ? head.tstamp  : '0;
  assign ts_spid_o    = ts_valid_o ? head.spid    : '0;
  assign ts_seqid_o   = ts_valid_o ? head.seqid   : '0;
  assign ts_msgtype_o = ts_valid_o ? head.msgtype : '0;
  assign ts_count_o   = count_q;
  assign ts_ovf_cnt_o = ovf_q;
  assign int_tx_ptp_o = commit_q;
  assign txd_o        = txd_q;
  assign txc_o        = txc_q;

endmodule

// File: tb/tb_tx_tse_tsq.sv
// Bench for tx_tse_tsq. Frames are built as byte arrays counted from the DA.
// A frame-level model decides from the byte array whether the frame is
// stamped and what its record holds. Records go into a scoreboard queue.
// A monitor pops the DUT queue and compares each head to the scoreboard.
module tb_tx_tse_tsq;
  localparam int          DEPTH    = 8;
  localparam int          AW       = 3;
  localparam logic [15:0] MSG_MASK = 16'h000F;
`ifdef TX_TSE_TSQ_VLAN_EN
  localparam bit VLAN_MODEL = 1'b1;
`else
  localparam bit VLAN_MODEL = 1'b0;
`endif
  localparam logic [63:0] IDLE_W = {8{8'h07}};

  typedef struct packed {
    logic [95:0] tstamp;
    logic [79:0] spid;
    logic [15:0] seqid;
    logic [3:0]  msgtype;
  } rec_t;

  logic          tx_clk, tx_rst, tx_clk_en_i;
  logic [63:0]   txd_i, txd_o;
  logic [7:0]    txc_i, txc_o;
  logic [79:0]   sfd_timestamp_i;
  logic [15:0]   sfd_ts_frac_ns_i;
  logic [31:0]   tsu_cfg_i;
  logic          ts_valid_o, ts_pop_i, int_tx_ptp_o;
  logic [95:0]   ts_time_o;
  logic [79:0]   ts_spid_o;
  logic [15:0]   ts_seqid_o;
  logic [3:0]    ts_msgtype_o;
  logic [AW:0]   ts_count_o;
  logic [7:0]    ts_ovf_cnt_o;

  rec_t       exp_q[$];
  int         n_chk, n_fail, exp_ovf, exp_int, int_cnt;
  bit         pop_en, pop_on_int, rand_en, pt_on;
  logic [7:0] fr [0:127];
  int         fr_len;

  tx_tse_tsq #(.DEPTH(DEPTH), .AW(AW), .MSG_MASK(MSG_MASK)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .tx_clk_en_i(tx_clk_en_i),
    .txd_i(txd_i), .txc_i(txc_i), .txd_o(txd_o), .txc_o(txc_o),
    .sfd_timestamp_i(sfd_timestamp_i), .sfd_ts_frac_ns_i(sfd_ts_frac_ns_i),
    .tsu_cfg_i(tsu_cfg_i), .ts_valid_o(ts_valid_o), .ts_pop_i(ts_pop_i),
    .ts_time_o(ts_time_o), .ts_spid_o(ts_spid_o), .ts_seqid_o(ts_seqid_o),
    .ts_msgtype_o(ts_msgtype_o), .ts_count_o(ts_count_o),
    .ts_ovf_cnt_o(ts_ovf_cnt_o), .int_tx_ptp_o(int_tx_ptp_o)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d records still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] rts();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Hold a word on the bus until one enabled cycle has consumed it
  task automatic put_word(input logic [63:0] d, input logic [7:0] c, input logic [95:0] ts);
    txd_i = d;
    txc_i = c;
    {sfd_timestamp_i, sfd_ts_frac_ns_i} = ts;
    forever begin
      tx_clk_en_i = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge tx_clk);
      #1;
      if (tx_clk_en_i) break;
    end
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) put_word(IDLE_W, 8'hFF, rts());
  endtask

  task automatic build(input logic [15:0] et, input bit tag, input logic [3:0] mt,
                       input logic [3:0] ver, input logic [15:0] sq);
    int p;
    logic [7:0] rb;
    fr_len = $urandom_range(64, 96);
    for (int i = 0; i < 128; i++) fr[i] = 8'($urandom);
    p = 12;
    if (tag) begin
      fr[12] = 8'h81;
      fr[13] = 8'h00;
      p = 16;
    end
    fr[p]   = et[15:8];
    fr[p+1] = et[7:0];
    rb = 8'($urandom);
    fr[p+2] = {rb[7:4], mt};
    rb = 8'($urandom);
    fr[p+3] = {rb[7:4], ver};
    fr[p+32] = sq[15:8];
    fr[p+33] = sq[7:0];
  endtask

  // Model the frame, then transmit it. err_word puts an FE error char in that
  // word; abort_word stops transmission after that word.
  task automatic send_frame(input int err_word, input int abort_word, input logic [95:0] ts);
    int         off, idx, last;
    logic [15:0] et;
    bit         push;
    rec_t       r;
    logic [63:0] d;
    logic [7:0] c;
    off = 12;
    if (VLAN_MODEL && fr[12] == 8'h81 && fr[13] == 8'h00) off = 16;
    et = {fr[off], fr[off+1]};
    push = tsu_cfg_i[0] && et == 16'h88F7 && fr[off+3][3:0] == 4'd2 && MSG_MASK[fr[off+2][3:0]];
    // An error char anywhere up to the sequenceId word kills the record
    if (err_word > 0 && 8 * (err_word - 1) <= off + 33) push = 1'b0;
    if (abort_word > 0) push = 1'b0;
    if (push) begin
      r.tstamp  = ts;
      r.msgtype = fr[off+2][3:0];
      r.seqid   = {fr[off+32], fr[off+33]};
      for (int i = 0; i < 10; i++) r.spid[79-8*i -: 8] = fr[off+22+i];
      exp_int++;
      if (pop_en || pop_on_int || exp_q.size() < DEPTH) exp_q.push_back(r);
      else if (exp_ovf < 255) exp_ovf++;
    end
    put_word(64'hD5555555555555FB, 8'h01, ts);
    last = fr_len / 8 + 1;
    for (int k = 1; k <= last; k++) begin
      for (int n = 0; n < 8; n++) begin
        idx = 8 * (k - 1) + n;
        if (idx < fr_len)       begin d[8*n +: 8] = fr[idx]; c[n] = 1'b0; end
        else if (idx == fr_len) begin d[8*n +: 8] = 8'hFD;   c[n] = 1'b1; end
        else                    begin d[8*n +: 8] = 8'h07;   c[n] = 1'b1; end
      end
      if (k == err_word) begin
        d[31:24] = 8'hFE;
        c[3]     = 1'b1;
      end
      put_word(d, c, rts());
      if (k == abort_word) return;
    end
    idles($urandom_range(1, 3));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge tx_clk);
      n++;
    end
    repeat (3) @(posedge tx_clk);
    #1;
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_count"}, ts_count_o, 0);
    chk({nm, "_valid"}, ts_valid_o, 0);
  endtask

  // Scoreboard monitor: pops the DUT head and compares it with the model
  initial begin : sb_mon
    rec_t r;
    ts_pop_i = 1'b0;
    forever begin
      @(negedge tx_clk);
      ts_pop_i = 1'b0;
      if (ts_valid_o === 1'b1 && (pop_en || (pop_on_int && int_tx_ptp_o === 1'b1))) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL head_unexpected: got seqid %0h, want no record", ts_seqid_o);
        end else begin
          r = exp_q.pop_front();
          chk("head_rec", {ts_time_o, ts_spid_o, ts_seqid_o, ts_msgtype_o}, r);
        end
        ts_pop_i = 1'b1;
      end
    end
  end

  initial begin : int_mon
    int_cnt = 0;
    forever begin
      @(negedge tx_clk);
      if (int_tx_ptp_o === 1'b1) int_cnt++;
    end
  end

  // Pass-through: output equals the input from the last enabled cycle
  initial begin : pt_mon
    logic [63:0] ed;
    logic [7:0]  ec;
    ed = IDLE_W;
    ec = 8'hFF;
    forever begin
      @(posedge tx_clk);
      if (tx_rst) begin
        ed = IDLE_W;
        ec = 8'hFF;
      end else if (tx_clk_en_i) begin
        ed = txd_i;
        ec = txc_i;
      end
      #2;
      if (pt_on) chk("passthru", {txc_o, txd_o}, {ec, ed});
    end
  end

  initial begin : main
    logic [15:0] et;
    bit          tag;
    n_chk = 0; n_fail = 0; exp_ovf = 0; exp_int = 0;
    pop_en = 0; pop_on_int = 0; rand_en = 0; pt_on = 0;
    tx_rst = 1'b1;
    tx_clk_en_i = 1'b1;
    txd_i = IDLE_W;
    txc_i = 8'hFF;
    {sfd_timestamp_i, sfd_ts_frac_ns_i} = '0;
    tsu_cfg_i = 32'h0;
    repeat (3) @(posedge tx_clk);
    #1;
    chk("rst_txd", txd_o, IDLE_W);
    chk("rst_txc", txc_o, 8'hFF);
    chk("rst_valid", ts_valid_o, 0);
    chk("rst_count", ts_count_o, 0);
    chk("rst_ovf", ts_ovf_cnt_o, 0);
    chk("rst_int", int_tx_ptp_o, 0);
    chk("rst_head", {ts_time_o, ts_spid_o, ts_seqid_o, ts_msgtype_o}, 0);
    tx_rst = 1'b0;
    pt_on = 1;
    tsu_cfg_i = 32'h1;
    idles(2);

    // Single Sync with a known timestamp
    build(16'h88F7, 0, 4'd0, 4'd2, 16'h1234);
    send_frame(0, 0, {80'h1_00000064, 16'h0});
    idles(2);
    chk("sync_count", ts_count_o, 1);
    chk("sync_valid", ts_valid_o, 1);
    chk("sync_seqid", ts_seqid_o, 16'h1234);
    chk("sync_type", ts_msgtype_o, 0);
    chk("sync_time", ts_time_o, {80'h1_00000064, 16'h0});
    chk("sync_int", int_cnt, 1);
    pop_en = 1;
    drain("sync");

    // Masked message type and a non-PTP ethertype
    build(16'h88F7, 0, 4'd8, 4'd2, 16'h0055);
    send_frame(0, 0, rts());
    build(16'h0800, 0, 4'd0, 4'd2, 16'h0056);
    send_frame(0, 0, rts());
    idles(2);
    chk("nopush_count", ts_count_o, 0);
    chk("nopush_int", int_cnt, exp_int);

    // Error char at word 4, then a good Sync
    build(16'h88F7, 0, 4'd0, 4'd2, 16'h0077);
    send_frame(4, 0, rts());
    build(16'h88F7, 0, 4'd0, 4'd2, 16'h0078);
    send_frame(0, 0, rts());
    drain("err");

    // Ten back-to-back Delay_Req with no pops
    pop_en = 0;
    for (int i = 0; i < 10; i++) begin
      build(16'h88F7, 0, 4'd1, 4'd2, 16'h0100 + 16'(i));
      send_frame(0, 0, rts());
    end
    chk("b2b_count", ts_count_o, 8);
    chk("b2b_ovf", ts_ovf_cnt_o, exp_ovf);
    chk("b2b_ovf_val", exp_ovf, 2);
    chk("b2b_int", int_cnt, exp_int);
    pop_en = 1;
    drain("b2b");

    // Overflow clear
    tsu_cfg_i = 32'h3;
    idles(2);
    exp_ovf = 0;
    chk("ovf_clear", ts_ovf_cnt_o, exp_ovf);
    tsu_cfg_i = 32'h1;

    // Full queue with pop and commit in the same cycle
    pop_en = 0;
    for (int i = 0; i < 8; i++) begin
      build(16'h88F7, 0, 4'd0, 4'd2, 16'h0200 + 16'(i));
      send_frame(0, 0, rts());
    end
    chk("full_count", ts_count_o, 8);
    pop_on_int = 1;
    build(16'h88F7, 0, 4'd3, 4'd2, 16'h0208);
    send_frame(0, 0, rts());
    pop_on_int = 0;
    idles(2);
    chk("fullpop_count", ts_count_o, 8);
    chk("fullpop_ovf", ts_ovf_cnt_o, exp_ovf);
    pop_en = 1;
    drain("fullpop");

    // Engine disabled: no new frames
    tsu_cfg_i = 32'h0;
    build(16'h88F7, 0, 4'd0, 4'd2, 16'h0300);
    send_frame(0, 0, rts());
    idles(2);
    chk("dis_count", ts_count_o, 0);
    tsu_cfg_i = 32'h1;

    // Tagged Pdelay_Req
    pop_en = 0;
    build(16'h88F7, 1, 4'd2, 4'd2, 16'h0007);
    send_frame(0, 0, rts());
    idles(2);
    chk("vlan_count", ts_count_o, VLAN_MODEL ? 1 : 0);
    pop_en = 1;
    drain("vlan");

    // Randomised traffic with clock-enable gaps
    rand_en = 1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       begin et = 16'h0800; tag = 0; end
        1:       begin et = 16'h88F7; tag = 1; end
        default: begin et = 16'h88F7; tag = 0; end
      endcase
      build(et, tag, 4'($urandom_range(0, 9)), ($urandom_range(0, 5) == 0) ? 4'd1 : 4'd2,
            16'($urandom));
      send_frame(($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 0, 0, rts());
    end
    rand_en = 0;
    drain("rand");

    // Reset in the middle of a frame
    pop_en = 0;
    build(16'h88F7, 0, 4'd0, 4'd2, 16'h0400);
    send_frame(0, 0, rts());
    build(16'h88F7, 0, 4'd0, 4'd2, 16'h0401);
    send_frame(0, 3, rts());
    tx_rst = 1'b1;
    exp_q.delete();
    exp_ovf = 0;
    repeat (2) @(posedge tx_clk);
    #1;
    chk("midrst_count", ts_count_o, 0);
    chk("midrst_valid", ts_valid_o, 0);
    chk("midrst_txd", txd_o, IDLE_W);
    tx_rst = 1'b0;
    idles(2);
    build(16'h88F7, 0, 4'd0, 4'd2, 16'h0402);
    send_frame(0, 0, rts());
    pop_en = 1;
    drain("postrst");

    chk("final_int", int_cnt, exp_int);
    chk("final_ovf", ts_ovf_cnt_o, exp_ovf);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
